// File: rtl/rom_scan_ctrl_pkg.sv
// Shared definitions for the ROM scan sequencer: FSM state encoding and a
// constant-evaluable ceiling-log2 helper used for derived widths.
package rom_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SHOW = 2'd2
    } scan_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rom_scan_tick.sv
// Step prescaler for the ROM scan sequencer: counts 0..TICKS-1 while enabled
// and flags the last count; clr_i has priority and restarts the count at 0.
module rom_scan_tick
    import rom_scan_ctrl_pkg::*;
#(
    parameter int TICKS = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (clog2(TICKS) > 0) ? clog2(TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // A paused count keeps its partial value, so the tick only fires while enabled.
    assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/rom_scan_ctrl.sv
// ROM + 7-seg scan sequencer: walks every ROM word once and steps its nibbles
// onto the display. Define ROM_SCAN_LOOP_EN to rescan continuously.
module rom_scan_ctrl
    import rom_scan_ctrl_pkg::*;
#(
    parameter int D       = 3,
    parameter int W       = 32,
    parameter int CLK_HZ  = 10_000_000,
    parameter int STEP_HZ = 4,
    localparam int NIB    = W / 4,
    localparam int SW     = (clog2(NIB) > 0) ? clog2(NIB) : 1,
    localparam int TICKS  = CLK_HZ / STEP_HZ
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic          pause_i,
    input  logic [W-1:0]  dato_i,
    output logic [D-1:0]  addr_o,
    output logic          rden_o,
    output logic [3:0]    nibble_o,
    output logic [SW-1:0] nibsel_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam logic [SW-1:0] NIB_LAST  = SW'(NIB - 1);
    localparam logic [D-1:0]  ADDR_LAST = {D{1'b1}};

    function automatic logic [3:0] nib_of(input logic [W-1:0] w, input logic [SW-1:0] idx);
        return w[int'(idx) * 4 +: 4];
    endfunction

    scan_state_e   state_q, state_d;
    logic [D-1:0]  addr_q, addr_d;
    logic [SW-1:0] nibsel_q, nibsel_d;
    logic [3:0]    nibble_q, nibble_d;
    logic [W-1:0]  word_q, word_d;
    logic          rden_q, rden_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          tick_en, tick_clr, tick;

    assign tick_en  = (state_q == ST_SHOW) && !pause_i;
    assign tick_clr = (state_q != ST_SHOW) || stop_i;

    rom_scan_tick #(
        .TICKS (TICKS)
    ) u_tick (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (tick_en),
        .clr_i  (tick_clr),
        .tick_o (tick)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            nibsel_q <= '0;
            nibble_q <= '0;
            word_q   <= '0;
            rden_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            nibsel_q <= nibsel_d;
            nibble_q <= nibble_d;
            word_q   <= word_d;
            rden_q   <= rden_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        nibsel_d = nibsel_q;
        nibble_d = nibble_q;
        word_d   = word_q;
        done_d   = 1'b0;

        // stop outranks start and any pending tick; the display keeps its last nibble.
        if (stop_i) begin
            state_d  = ST_IDLE;
            addr_d   = '0;
            nibsel_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d = ST_LOAD;
                        addr_d  = '0;
                    end
                end
                ST_LOAD: begin
                    word_d   = dato_i;
                    nibsel_d = '0;
                    nibble_d = dato_i[3:0];
                    state_d  = ST_SHOW;
                end
                ST_SHOW: begin
                    if (tick) begin
                        if (nibsel_q != NIB_LAST) begin
                            nibsel_d = nibsel_q + 1'b1;
                            nibble_d = nib_of(word_q, nibsel_q + 1'b1);
                        end else if (addr_q != ADDR_LAST) begin
                            addr_d  = addr_q + 1'b1;
                            state_d = ST_LOAD;
                        end else begin
                            done_d = 1'b1;
                            addr_d = '0;
`ifdef ROM_SCAN_LOOP_EN
                            state_d = ST_LOAD;
`else
                            state_d = ST_IDLE;
`endif
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        rden_d = (state_d == ST_LOAD);
        busy_d = (state_d != ST_IDLE);
    end

    assign addr_o   = addr_q;
    assign rden_o   = rden_q;
    assign nibble_o = nibble_q;
    assign nibsel_o = nibsel_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_rom_scan_ctrl.sv
// Self-checking bench for rom_scan_ctrl (D=2, W=8, TICKS=4): directed table,
// hand-written corner sequences and a randomized run against a segment model.
module tb_rom_scan_ctrl;

    localparam int D       = 2;
    localparam int W       = 8;
    localparam int CLK_HZ  = 8;
    localparam int STEP_HZ = 2;
    localparam int TICKS   = 4;
    localparam int NIB     = 2;
    localparam int SW      = 1;
    localparam int SEG_PER = NIB + 1;
    localparam int SEGS    = (1 << D) * SEG_PER;
`ifdef ROM_SCAN_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, start, stop, pause;
    logic [W-1:0]  dato;
    logic [D-1:0]  addr;
    logic          rden, busy, done;
    logic [3:0]    nibble;
    logic [SW-1:0] nibsel;
    logic [7:0]    rom [4];

    assign dato = rom[addr];
    always #5 clk = ~clk;

    rom_scan_ctrl #(
        .D       (D),
        .W       (W),
        .CLK_HZ  (CLK_HZ),
        .STEP_HZ (STEP_HZ)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start),
        .stop_i   (stop),
        .pause_i  (pause),
        .dato_i   (dato),
        .addr_o   (addr),
        .rden_o   (rden),
        .nibble_o (nibble),
        .nibsel_o (nibsel),
        .busy_o   (busy),
        .done_o   (done)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bundle", 32'({rden, done, addr, nibsel, nibble}), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    function automatic logic [3:0] rom_nib(input int a, input int k);
        logic [7:0] w;
        w = rom[a];
        return w[4 * k +: 4];
    endfunction

    // Segment model: each word is one LOAD segment followed by NIB display
    // segments, each lasting TICKS unpaused cycles.
    bit         m_active;
    int         m_seg, m_el, m_sel;
    logic [3:0] m_nib;
    bit         m_done;

    task automatic model_reset();
        m_active = 1'b0;
        m_seg = 0;
        m_el = 0;
        m_sel = 0;
        m_nib = 4'h0;
        m_done = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit sp, input bit p);
        int a, j;
        a = m_seg / SEG_PER;
        j = m_seg % SEG_PER;
        m_done = 1'b0;
        if (sp) begin
            m_active = 1'b0;
            m_sel = 0;
        end else if (!m_active) begin
            if (s) begin
                m_active = 1'b1;
                m_seg = 0;
                m_el = 0;
            end
        end else if (j == 0) begin
            m_seg++;
            m_el = 0;
            m_sel = 0;
            m_nib = rom_nib(a, 0);
        end else if (!p) begin
            m_el++;
            if (m_el == TICKS) begin
                m_el = 0;
                if (j < NIB) begin
                    m_seg++;
                    m_sel = j;
                    m_nib = rom_nib(a, j);
                end else if (m_seg == SEGS - 1) begin
                    m_done = 1'b1;
                    if (LOOP) m_seg = 0;
                    else m_active = 1'b0;
                end else begin
                    m_seg++;
                end
            end
        end
    endtask

    task automatic model_cmp();
        logic [10:0] act_v, exp_v;
        logic        e_rden;
        logic [1:0]  e_addr;
        e_rden = m_active && (m_seg % SEG_PER == 0);
        e_addr = m_active ? 2'(m_seg / SEG_PER) : 2'd0;
        act_v = {busy, rden, done, addr, nibsel, nibble};
        exp_v = {m_active, e_rden, m_done, e_addr, 1'(m_sel), m_nib};
        chk("rand_bundle", 32'(act_v), 32'(exp_v));
    endtask

    typedef struct {
        int         c;
        logic       rden;
        logic [1:0] addr;
        logic [3:0] nib;
        logic       sel;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, n;
        bit found, seen, low;
        bit s, sp;

        rom[0] = 8'hA5;
        rom[1] = 8'h3C;
        rom[2] = 8'h7E;
        rom[3] = 8'h01;

        tbl[0]  = '{0,  1'b1, 2'd0, 4'h0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1,  1'b0, 2'd0, 4'h5, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{4,  1'b0, 2'd0, 4'h5, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{5,  1'b0, 2'd0, 4'hA, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{8,  1'b0, 2'd0, 4'hA, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{9,  1'b1, 2'd1, 4'hA, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{10, 1'b0, 2'd1, 4'hC, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{14, 1'b0, 2'd1, 4'h3, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{18, 1'b1, 2'd2, 4'h3, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{19, 1'b0, 2'd2, 4'hE, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{23, 1'b0, 2'd2, 4'h7, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{27, 1'b1, 2'd3, 4'h7, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{28, 1'b0, 2'd3, 4'h1, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{32, 1'b0, 2'd3, 4'h0, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{35, 1'b0, 2'd3, 4'h0, 1'b1, 1'b1, 1'b0};
        tbl[15] = '{36, LOOP, 2'd0, 4'h0, 1'b1, LOOP, 1'b1};
        if (LOOP) tbl[16] = '{37, 1'b0, 2'd0, 4'h5, 1'b0, 1'b1, 1'b0};
        else      tbl[16] = '{37, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0};

        // Full pass, directed table
        do_reset();
        pulse_start();
        c = 0;
        for (int i = 0; i < 17; i++) begin
            while (c < tbl[i].c) begin
                cyc();
                c++;
            end
            chk($sformatf("t2_rden_c%0d", c), 32'(rden), 32'(tbl[i].rden));
            chk($sformatf("t2_addr_c%0d", c), 32'(addr), 32'(tbl[i].addr));
            chk($sformatf("t2_nib_c%0d", c), 32'(nibble), 32'(tbl[i].nib));
            chk($sformatf("t2_sel_c%0d", c), 32'(nibsel), 32'(tbl[i].sel));
            chk($sformatf("t2_busy_c%0d", c), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("t2_done_c%0d", c), 32'(done), 32'(tbl[i].done));
        end

        // Async reset in the middle of SHOW
        do_reset();
        pulse_start();
        repeat (6) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_busy_async", 32'(busy), 32'd0);
        chk("t1_outs_async", 32'({rden, done, addr, nibsel, nibble}), 32'd0);
        #3;
        rst_n = 1'b1;
        cyc();
        repeat (5) cyc();
        chk("t1_idle_after", 32'({busy, rden, addr}), 32'd0);

        // Pause during nibble 'A'
        do_reset();
        pulse_start();
        repeat (5) cyc();
        chk("t3_at_A", 32'(nibble), 32'hA);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            pause = (k < 10);
            if (nibble == 4'hA && !rden && busy) n++;
            cyc();
        end
        pause = 1'b0;
        chk("t3_A_cycles", 32'(n), 32'd14);

        // Stop at addr 2, start while busy ignored
        do_reset();
        pulse_start();
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (addr == 2'd2 && !rden) found = 1'b1;
            else cyc();
        end
        chk("t4_reach_addr2", 32'(found), 32'd1);
        pulse_start();
        chk("t4_start_ignored", 32'(addr), 32'd2);
        chk("t4_busy", 32'(busy), 32'd1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("t4_stop_busy", 32'(busy), 32'd0);
        chk("t4_stop_addr", 32'(addr), 32'd0);
        chk("t4_stop_sel", 32'(nibsel), 32'd0);
        seen = 1'b0;
        low = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (done) seen = 1'b1;
            if (busy) low = 1'b0;
            cyc();
        end
        chk("t4_no_done", 32'(seen), 32'd0);
        chk("t4_stays_idle", 32'(low), 32'd1);

        // start and stop together while idle
        do_reset();
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_rden", 32'(rden), 32'd0);
        repeat (3) cyc();
        chk("t6_busy_later", 32'(busy), 32'd0);

        if (LOOP) begin
            do_reset();
            pulse_start();
            n = 0;
            low = 1'b0;
            for (int k = 0; k < 75; k++) begin
                if (done) n++;
                if (!busy) low = 1'b1;
                cyc();
            end
            chk("t5_done_pulses", 32'(n), 32'd2);
            chk("t5_busy_dropped", 32'(low), 32'd0);
            stop = 1'b1;
            cyc();
            stop = 1'b0;
        end

        // Randomized run against the segment model
        do_reset();
        model_reset();
        model_cmp();
        for (int k = 0; k < 3000; k++) begin
            s  = ($urandom_range(0, 19) == 0);
            sp = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            start = s;
            stop  = sp;
            cyc();
            model_step(s, sp, pause);
            model_cmp();
        end
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
